// File: rtl/rvdmi_cdc_bridge.sv
// DMI request bridge from the JTAG tck domain to the core clk domain.
// Requests cross over a toggle handshake. Responses return the same way.
module rvdmi_cdc_bridge #(
    parameter int AWIDTH      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              tck,
    input  logic              clk,
    input  logic              trst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              dmi_reset,
    input  logic              dmi_hard_reset,
    output logic [31:0]       rd_data,
    output logic [1:0]        rd_status,
    output logic [1:0]        dmi_stat,
    output logic              dmi_req_valid,
    input  logic              dmi_req_ready,
    output logic [AWIDTH-1:0] dmi_req_addr,
    output logic [31:0]       dmi_req_data,
    output logic [1:0]        dmi_req_op,
    input  logic              dmi_rsp_valid,
    input  logic [31:0]       dmi_rsp_data,
    input  logic              dmi_rsp_err
);
    localparam logic [1:0] OP_READ   = 2'd1;
    localparam logic [1:0] OP_WRITE  = 2'd2;
    localparam logic [1:0] ST_OK     = 2'd0;
    localparam logic [1:0] ST_FAILED = 2'd2;
    localparam logic [1:0] ST_BUSY   = 2'd3;

    typedef enum logic       {T_IDLE, T_PEND}          tck_state_t;
    typedef enum logic [1:0] {C_IDLE, C_ISSUE, C_WAIT} clk_state_t;

    tck_state_t             t_state, t_state_nxt;
    logic                   req_tgl, ack_seen, discard;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [AWIDTH-1:0]      hold_addr;
    logic [31:0]            hold_data;
    logic [1:0]             hold_op;
    logic [1:0]             last, sticky;
    logic                   req_in, ack_edge, launch, capture;

    clk_state_t             c_state, c_state_nxt;
    logic [SYNC_STAGES-1:0] rst_sync, req_sync;
    logic                   rst_clk;
    logic                   req_seen, ack_tgl, rsp_err_q;
    logic [31:0]            rsp_data_q;
    logic                   req_edge, load, take_rsp, drop_valid;

    assign req_in   = wr_en | rd_en;
    assign ack_edge = ack_sync[SYNC_STAGES-1] ^ ack_seen;

    always_comb begin
        t_state_nxt = t_state;
        launch      = 1'b0;
        capture     = 1'b0;
        case (t_state)
            T_IDLE: if (req_in) begin
                launch      = 1'b1;
                t_state_nxt = T_PEND;
            end
            T_PEND: if (ack_edge) begin
                capture     = !discard;
                t_state_nxt = T_IDLE;
            end
            default: t_state_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            t_state   <= T_IDLE;
            req_tgl   <= 1'b0;
            ack_sync  <= '0;
            ack_seen  <= 1'b0;
            discard   <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
            hold_op   <= 2'd0;
            rd_data   <= '0;
            last      <= ST_OK;
            sticky    <= ST_OK;
        end else begin
            t_state  <= t_state_nxt;
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_tgl};
            ack_seen <= ack_sync[SYNC_STAGES-1];
            if (launch) begin
                req_tgl   <= ~req_tgl;
                hold_addr <= wr_addr;
                hold_data <= wr_data;
                hold_op   <= wr_en ? OP_WRITE : OP_READ;
            end
            if (capture && hold_op == OP_READ)
                rd_data <= rsp_data_q;
            // The handshake must still complete after a hard reset, so only its result is dropped.
            if (t_state == T_PEND && ack_edge)
                discard <= 1'b0;
            else if (t_state == T_PEND && dmi_hard_reset)
                discard <= 1'b1;
            // dmi_reset clears the reported error along with the sticky one.
            if (dmi_reset || dmi_hard_reset) begin
                sticky <= ST_OK;
                last   <= ST_OK;
            end else begin
                if (capture)
                    last <= rsp_err_q ? ST_FAILED : ST_OK;
                if (sticky == ST_OK) begin
                    if (t_state == T_PEND && req_in)
                        sticky <= ST_BUSY;
                    else if (capture && rsp_err_q)
                        sticky <= ST_FAILED;
                end
            end
        end
    end

    assign rd_status = (t_state == T_PEND) ? ST_BUSY : ((sticky != ST_OK) ? sticky : last);
    assign dmi_stat  = sticky;

    always_ff @(posedge clk or negedge trst) begin
        if (!trst)
            rst_sync <= '0;
        else
            rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
    end
    assign rst_clk = rst_sync[SYNC_STAGES-1];

    assign req_edge = req_sync[SYNC_STAGES-1] ^ req_seen;

    always_comb begin
        c_state_nxt = c_state;
        load        = 1'b0;
        take_rsp    = 1'b0;
        drop_valid  = 1'b0;
        case (c_state)
            C_IDLE: if (req_edge) begin
                load        = 1'b1;
                c_state_nxt = C_ISSUE;
            end
            C_ISSUE: if (dmi_req_ready) begin
                drop_valid = 1'b1;
                if (dmi_rsp_valid) begin
                    take_rsp    = 1'b1;
                    c_state_nxt = C_IDLE;
                end else begin
                    c_state_nxt = C_WAIT;
                end
            end
            C_WAIT: if (dmi_rsp_valid) begin
                take_rsp    = 1'b1;
                c_state_nxt = C_IDLE;
            end
            default: c_state_nxt = C_IDLE;
        endcase
    end

    // The hold registers are stable from the req_tgl flip until the ack, so they are sampled raw.
    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            c_state       <= C_IDLE;
            req_sync      <= '0;
            req_seen      <= 1'b0;
            ack_tgl       <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_data_q    <= '0;
            dmi_req_valid <= 1'b0;
            dmi_req_addr  <= '0;
            dmi_req_data  <= '0;
            dmi_req_op    <= 2'd0;
        end else begin
            c_state  <= c_state_nxt;
            req_sync <= {req_sync[SYNC_STAGES-2:0], req_tgl};
            req_seen <= req_sync[SYNC_STAGES-1];
            if (load) begin
                dmi_req_valid <= 1'b1;
                dmi_req_addr  <= hold_addr;
                dmi_req_data  <= hold_data;
                dmi_req_op    <= hold_op;
            end else if (drop_valid) begin
                dmi_req_valid <= 1'b0;
            end
            if (take_rsp) begin
                rsp_data_q <= dmi_rsp_data;
                rsp_err_q  <= dmi_rsp_err;
                ack_tgl    <= ~ack_tgl;
            end
        end
    end
endmodule

// File: tb/tb_rvdmi_cdc_bridge.sv
`timescale 1ns/1ps
// Scoreboard bench for rvdmi_cdc_bridge: a clk-side monitor checks core requests,
// and the tck-side status and data are checked against a transaction-level model.
module tb_rvdmi_cdc_bridge;
    localparam int AW = 7;

    logic          tck = 1'b0, clk = 1'b0, trst = 1'b0;
    logic          wr_en, rd_en, dmi_reset, dmi_hard_reset;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data, rd_data;
    logic [1:0]    rd_status, dmi_stat;
    logic          dmi_req_valid, dmi_req_ready;
    logic [AW-1:0] dmi_req_addr;
    logic [31:0]   dmi_req_data;
    logic [1:0]    dmi_req_op;
    logic          dmi_rsp_valid, dmi_rsp_err;
    logic [31:0]   dmi_rsp_data;

    int tck_half = 5;
    int clk_half = 25;
    always #(tck_half) tck = ~tck;
    always #(clk_half) clk = ~clk;

    rvdmi_cdc_bridge #(.AWIDTH(AW), .SYNC_STAGES(2)) dut (
        .tck(tck), .clk(clk), .trst(trst),
        .wr_en(wr_en), .rd_en(rd_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dmi_reset(dmi_reset), .dmi_hard_reset(dmi_hard_reset),
        .rd_data(rd_data), .rd_status(rd_status), .dmi_stat(dmi_stat),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
        .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_err(dmi_rsp_err)
    );

    typedef struct { logic [1:0] op; logic [AW-1:0] addr; logic [31:0] data; } req_t;
    typedef struct { int rdly; int sdly; logic [31:0] data; logic err; } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int compared = 0, mismatched = 0;
    int issued = 0, seen = 0, rsp_count = 0;

    logic [31:0] m_rd_data;
    logic [1:0]  m_sticky, m_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_status();
        return (m_sticky != 2'd0) ? m_sticky : m_last;
    endfunction

    // Core-side responder: ready after rdly cycles, response sdly cycles after acceptance.
    initial begin
        rsp_t r;
        dmi_req_ready = 1'b0; dmi_rsp_valid = 1'b0; dmi_rsp_data = '0; dmi_rsp_err = 1'b0;
        forever begin
            @(negedge clk);
            if (dmi_req_valid && rsp_q.size() > 0) begin
                r = rsp_q.pop_front();
                repeat (r.rdly) @(negedge clk);
                dmi_req_ready = 1'b1;
                if (r.sdly == 0) begin
                    dmi_rsp_valid = 1'b1; dmi_rsp_data = r.data; dmi_rsp_err = r.err;
                end
                @(negedge clk);
                dmi_req_ready = 1'b0;
                if (r.sdly > 0) begin
                    repeat (r.sdly - 1) @(negedge clk);
                    dmi_rsp_valid = 1'b1; dmi_rsp_data = r.data; dmi_rsp_err = r.err;
                    @(negedge clk);
                end
                dmi_rsp_valid = 1'b0; dmi_rsp_data = $urandom; dmi_rsp_err = 1'b0;
                rsp_count++;
            end
        end
    end

    // Monitor: pops the expected request on every accepted core request.
    initial begin
        req_t          e;
        logic          pv, pr;
        logic [AW-1:0] pa;
        logic [31:0]   pd;
        logic [1:0]    po;
        pv = 1'b0; pr = 1'b0; pa = '0; pd = '0; po = '0;
        forever begin
            @(negedge clk);
            #1;
            if (dmi_req_valid && pv && !pr)
                check("req_hold", 64'({dmi_req_op, dmi_req_addr, dmi_req_data}), 64'({po, pa, pd}));
            if (dmi_req_valid && dmi_req_ready) begin
                seen++;
                if (req_q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_req: got op %0d addr 0x%0h, expected none", dmi_req_op, dmi_req_addr);
                end else begin
                    e = req_q.pop_front();
                    check("req_op",   64'(dmi_req_op),   64'(e.op));
                    check("req_addr", 64'(dmi_req_addr), 64'(e.addr));
                    check("req_data", 64'(dmi_req_data), 64'(e.data));
                end
            end
            pv = dmi_req_valid; pr = dmi_req_ready;
            pa = dmi_req_addr;  pd = dmi_req_data; po = dmi_req_op;
        end
    end

    // extra: 0 none, 1 second request while pending, 2 hard reset while pending.
    task automatic txn(input logic [1:0] op, input logic [AW-1:0] addr, input logic [31:0] data,
                       input logic [31:0] rdat, input logic err, input int rdly, input int sdly,
                       input int extra);
        req_t q;
        rsp_t r;
        int   base;
        bit   done, discard_m;
        q.op = op; q.addr = addr; q.data = data;
        req_q.push_back(q); issued++;
        r.rdly = rdly; r.sdly = sdly; r.data = rdat; r.err = err;
        rsp_q.push_back(r);
        base = rsp_count;
        discard_m = 1'b0;
        @(negedge tck);
        wr_en = (op == 2'd2); rd_en = (op == 2'd1); wr_addr = addr; wr_data = data;
        @(negedge tck);
        wr_en = 1'b0; rd_en = 1'b0; wr_addr = AW'($urandom); wr_data = $urandom;
        check("status_pend", 64'(rd_status), 64'(3));
        if (extra == 1) begin
            wr_en = 1'b1;
            if (m_sticky == 2'd0) m_sticky = 2'd3;
        end
        if (extra == 2) begin
            dmi_hard_reset = 1'b1;
            m_sticky = 2'd0; m_last = 2'd0; discard_m = 1'b1;
        end
        if (extra != 0) begin
            @(negedge tck);
            wr_en = 1'b0; dmi_hard_reset = 1'b0;
        end
        done = 1'b0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge tck);
            done = (rsp_count != base);
        end
        if (!done) begin
            compared++; mismatched++;
            $display("FAIL rsp_timeout: got no core response, expected one for addr 0x%0h", addr);
        end
        repeat (5) @(negedge tck);
        if (!discard_m) begin
            if (op == 2'd1) m_rd_data = rdat;
            m_last = err ? 2'd2 : 2'd0;
            if (err && m_sticky == 2'd0) m_sticky = 2'd2;
        end
        check("rd_status", 64'(rd_status), 64'(exp_status()));
        check("dmi_stat",  64'(dmi_stat),  64'(m_sticky));
        check("rd_data",   64'(rd_data),   64'(m_rd_data));
    endtask

    task automatic pulse_dmi_reset();
        @(negedge tck);
        dmi_reset = 1'b1;
        @(negedge tck);
        dmi_reset = 1'b0;
        m_sticky = 2'd0; m_last = 2'd0;
        check("stat_after_reset",   64'(dmi_stat),  64'(m_sticky));
        check("status_after_reset", 64'(rd_status), 64'(exp_status()));
    endtask

    task automatic random_txns(input int n);
        logic [1:0] op;
        for (int k = 0; k < n; k++) begin
            op = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2;
            if (m_sticky != 2'd0 && $urandom_range(0, 1) == 1)
                pulse_dmi_reset();
            txn(op, AW'($urandom), $urandom, $urandom, ($urandom_range(0, 7) == 0),
                $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end
    endtask

    initial begin
        bit got;
        wr_en = 1'b0; rd_en = 1'b0; wr_addr = '0; wr_data = '0;
        dmi_reset = 1'b0; dmi_hard_reset = 1'b0;
        m_rd_data = '0; m_sticky = 2'd0; m_last = 2'd0;
        trst = 1'b0;
        repeat (3) @(negedge tck);
        check("rst_rd_data",   64'(rd_data),       64'(0));
        check("rst_rd_status", 64'(rd_status),     64'(0));
        check("rst_dmi_stat",  64'(dmi_stat),      64'(0));
        check("rst_valid",     64'(dmi_req_valid), 64'(0));
        check("rst_req_op",    64'(dmi_req_op),    64'(0));
        trst = 1'b1;
        repeat (6) @(negedge clk);

        txn(2'd2, 7'h10, 32'hDEADBEEF, 32'h0,        1'b0, 0, 1, 0);
        txn(2'd1, 7'h11, $urandom,     32'h12345678, 1'b0, 5, 2, 0);
        txn(2'd1, 7'h12, $urandom,     32'hBAD0BAD0, 1'b1, 1, 1, 0);
        pulse_dmi_reset();
        txn(2'd2, 7'h13, 32'h55AA55AA, 32'h0,        1'b0, 20, 1, 1);
        pulse_dmi_reset();
        txn(2'd1, 7'h14, $urandom,     32'hCAFEF00D, 1'b0, 20, 1, 2);
        txn(2'd1, 7'h15, $urandom,     32'h0BADCAFE, 1'b0, 2, 0, 0);

        tck_half = 35; clk_half = 5;
        repeat (4) @(negedge tck);
        random_txns(100);
        tck_half = 5; clk_half = 25;
        repeat (4) @(negedge tck);
        random_txns(100);

        // trst while the core request sits unaccepted
        req_q.push_back('{op: 2'd1, addr: 7'h2A, data: 32'h0}); issued++;
        rsp_q.push_back('{rdly: 30, sdly: 1, data: 32'h1, err: 1'b0});
        @(negedge tck); rd_en = 1'b1; wr_addr = 7'h2A;
        @(negedge tck); rd_en = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            got = dmi_req_valid;
        end
        if (!got) begin
            compared++; mismatched++;
            $display("FAIL issue_timeout: got no dmi_req_valid, expected 1");
        end
        #1 trst = 1'b0;
        #1;
        check("trst_valid",     64'(dmi_req_valid), 64'(0));
        check("trst_req_addr",  64'(dmi_req_addr),  64'(0));
        check("trst_req_data",  64'(dmi_req_data),  64'(0));
        check("trst_req_op",    64'(dmi_req_op),    64'(0));
        check("trst_rd_data",   64'(rd_data),       64'(0));
        check("trst_rd_status", 64'(rd_status),     64'(0));
        check("trst_dmi_stat",  64'(dmi_stat),      64'(0));
        repeat (40) @(negedge clk);
        issued = issued - req_q.size();
        req_q.delete(); rsp_q.delete();
        m_rd_data = '0; m_sticky = 2'd0; m_last = 2'd0;
        trst = 1'b1;
        repeat (6) @(negedge clk);
        txn(2'd1, 7'h33, $urandom, 32'hA5A5F00F, 1'b0, 1, 1, 0);

        repeat (10) @(negedge clk);
        check("req_q_drained", 64'(req_q.size()), 64'(0));
        check("req_count",     64'(seen),         64'(issued));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no completion, expected finish before 5ms");
        $fatal(1, "watchdog");
    end
endmodule
